// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the three-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef logic [1:0] sel_t;

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Combinational round-robin picker: the first pending requester after 'last' wins.
module rr_pick3
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  sel_t               last,
    output logic               valid,
    output sel_t               idx
);

    // Scan order starts one past the previous winner; last=3 behaves like 2.
    always_comb begin
        valid = |req;
        idx   = 2'd0;
        case (last)
            2'd0: begin
                if (req[1])      idx = 2'd1;
                else if (req[2]) idx = 2'd2;
                else             idx = 2'd0;
            end
            2'd1: begin
                if (req[2])      idx = 2'd2;
                else if (req[0]) idx = 2'd0;
                else             idx = 2'd1;
            end
            default: begin
                if (req[0])      idx = 2'd0;
                else if (req[1]) idx = 2'd1;
                else             idx = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one 3:1 data mux, feeding a single valid/ready output register.
module mux3_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  din_0,
    input  logic [DATA_W-1:0]  din_1,
    input  logic [DATA_W-1:0]  din_2,
    output logic [NUM_REQ-1:0] ack,
    output sel_t               sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output sel_t               out_src
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    sel_t              out_src_q, out_src_d;
    sel_t              last_gnt_q, last_gnt_d;

    logic              can_load;
    logic              capture;
    logic              pick_valid;
    sel_t              pick_idx;
    logic [DATA_W-1:0] mux_data;

    rr_pick3 u_pick (
        .req   (req),
        .last  (last_gnt_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Nothing is granted while reset is held, so no ack can be lost to the reset edge.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        capture  = can_load && pick_valid && !rst;
        sel      = capture ? pick_idx : SEL_IDLE;
        ack      = '0;
        if (capture) ack[pick_idx] = 1'b1;
    end

    always_comb begin
        mux_data = '0;
        case (sel)
            2'd0:    mux_data = din_0;
            2'd1:    mux_data = din_1;
            2'd2:    mux_data = din_2;
            default: mux_data = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_gnt_d  = last_gnt_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_src_d   = pick_idx;
            last_gnt_d  = pick_idx;
        end else if (can_load) begin
            out_valid_d = 1'b0;
        end
    end

    // last_gnt resets to 2 so requester 0 is scanned first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            last_gnt_q  <= 2'd2;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed self-checking bench for mux3_rr_arbiter: reset, grants, round robin, stall, skip.
module tb_mux3_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] din_0, din_1, din_2;
    logic [2:0] ack;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;

    int checks = 0;
    int passed = 0;

    mux3_rr_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din_0     (din_0),
        .din_1     (din_1),
        .din_2     (din_2),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; out_ready = 1'b1;
        din_0 = 8'h11; din_1 = 8'h22; din_2 = 8'h33;
        #1;
        checks++;
        if ({ack, sel} !== {3'b000, 2'b11})
            $display("[TB] FAIL reset_comb ack/sel=%b/%b required 000/11", ack, sel);
        else passed++;
        tick(); tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b0, 8'h00, 2'd0})
            $display("[TB] FAIL reset_regs valid/data/src=%b/%h/%0d required 0/00/0", out_valid, out_data, out_src);
        else passed++;
        checks++;
        if ({ack, sel} !== {3'b000, 2'b11})
            $display("[TB] FAIL reset_held ack/sel=%b/%b required 000/11", ack, sel);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if ({ack, sel} !== {3'b001, 2'b00})
            $display("[TB] FAIL reset_first_grant ack/sel=%b/%b required 001/00", ack, sel);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h11, 2'd0})
            $display("[TB] FAIL reset_first_word valid/data/src=%b/%h/%0d required 1/11/0", out_valid, out_data, out_src);
        else passed++;
    endtask

    task automatic test_single();
        req = 3'b010; din_1 = 8'hA5; out_ready = 1'b1;
        #1;
        checks++;
        if ({ack, sel} !== {3'b010, 2'b01})
            $display("[TB] FAIL single_comb ack/sel=%b/%b required 010/01", ack, sel);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'hA5, 2'd1})
            $display("[TB] FAIL single_word valid/data/src=%b/%h/%0d required 1/a5/1", out_valid, out_data, out_src);
        else passed++;
        req = 3'b000;
        tick();
        checks++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL single_drain out_valid=%b required 0", out_valid);
        else passed++;
        din_1 = 8'h22;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [6];
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
        do_reset();
        req = 3'b111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (ack !== (3'b001 << (k % 3)))
                $display("[TB] FAIL rr_ack[%0d] ack=%b required %b", k, ack, 3'b001 << (k % 3));
            else passed++;
            tick();
            checks++;
            if ({out_valid, out_data, out_src} !== {1'b1, exp_data[k], 2'(k % 3)})
                $display("[TB] FAIL rr_word[%0d] valid/data/src=%b/%h/%0d required 1/%h/%0d", k, out_valid, out_data, out_src, exp_data[k], k % 3);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 3'b010; out_ready = 1'b1;
        tick();
        req = 3'b111; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({ack, sel} !== {3'b000, 2'b11})
                $display("[TB] FAIL stall_comb[%0d] ack/sel=%b/%b required 000/11", k, ack, sel);
            else passed++;
            tick();
            checks++;
            if ({out_valid, out_data, out_src} !== {1'b1, 8'h22, 2'd1})
                $display("[TB] FAIL stall_hold[%0d] valid/data/src=%b/%h/%0d required 1/22/1", k, out_valid, out_data, out_src);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({ack, sel} !== {3'b100, 2'b10})
            $display("[TB] FAIL stall_release ack/sel=%b/%b required 100/10", ack, sel);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h33, 2'd2})
            $display("[TB] FAIL stall_next_word valid/data/src=%b/%h/%0d required 1/33/2", out_valid, out_data, out_src);
        else passed++;
    endtask

    task automatic test_skip_withdraw();
        do_reset();
        req = 3'b001; out_ready = 1'b1;
        tick();
        req = 3'b100;
        #1;
        checks++;
        if ({ack, sel} !== {3'b100, 2'b10})
            $display("[TB] FAIL skip_comb ack/sel=%b/%b required 100/10", ack, sel);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h33, 2'd2})
            $display("[TB] FAIL skip_word valid/data/src=%b/%h/%0d required 1/33/2", out_valid, out_data, out_src);
        else passed++;
        req = 3'b000;
        #1;
        checks++;
        if ({ack, sel} !== {3'b000, 2'b11})
            $display("[TB] FAIL withdraw_comb ack/sel=%b/%b required 000/11", ack, sel);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL withdraw_drain out_valid=%b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b010; out_ready = 1'b1;
        tick();
        req = 3'b111; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ack, sel} !== {3'b000, 2'b11})
            $display("[TB] FAIL midrst_comb ack/sel=%b/%b required 000/11", ack, sel);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b0, 8'h00, 2'd0})
            $display("[TB] FAIL midrst_regs valid/data/src=%b/%h/%0d required 0/00/0", out_valid, out_data, out_src);
        else passed++;
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if ({ack, sel} !== {3'b001, 2'b00})
            $display("[TB] FAIL midrst_grant ack/sel=%b/%b required 001/00", ack, sel);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h11, 2'd0})
            $display("[TB] FAIL midrst_word valid/data/src=%b/%h/%0d required 1/11/0", out_valid, out_data, out_src);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_skip_withdraw();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
